// File: rtl/corefifo_gray_ptr_sync.sv
// Multi-channel synchroniser for Gray-coded FIFO pointers crossing into the clk domain.
// Each channel runs through a NUM_STAGES flop chain. The synchronised Gray value is
// converted to binary, and the channel reports the pointer advance since the previous
// sample plus a sticky flag for Gray steps that change more than one bit.
module corefifo_gray_ptr_sync #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned ADDRWIDTH  = 3,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned CHECK_EN   = 1
) (
    input  logic                                clk,
    input  logic                                arstn,
    input  logic                                srstn,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0]     inp,
    input  logic [NUM_CH-1:0]                   err_clr,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0]     sync_gray,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0]     sync_bin,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0]     ptr_delta,
    output logic [NUM_CH-1:0]                   ptr_chg,
    output logic [NUM_CH-1:0]                   gray_err
);

    localparam int P  = int'(ADDRWIDTH) + 1;
    localparam int W  = int'(NUM_CH) * P;
    localparam int NS = int'(NUM_STAGES);

    if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
        $error("corefifo_gray_ptr_sync: NUM_STAGES must be in 2..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
        $error("corefifo_gray_ptr_sync: NUM_CH must be in 1..8");
    end

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [P-1:0] g2b(input logic [P-1:0] g);
        logic [P-1:0] b;
        for (int i = 0; i < P; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [W-1:0]      stage_q [NS];
    logic [W-1:0]      prev_q;
    logic [W-1:0]      bin_q,   bin_d;
    logic [W-1:0]      delta_q, delta_d;
    logic [NUM_CH-1:0] chg_q,   chg_d;
    logic [NUM_CH-1:0] err_q,   err_d;

    // Synchroniser chain; both resets flush in-flight pointer values.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int k = 0; k < NS; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!srstn) begin
            for (int k = 0; k < NS; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= inp;
            for (int k = 1; k < NS; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [P-1:0] g_now;
        logic [P-1:0] g_prev;
        logic [P-1:0] b_now;
        logic [P-1:0] b_prev;
        logic         multi_bit;

        // Per-channel decode of the current synchronised sample against the previous one.
        always_comb begin
            g_now     = stage_q[NS-1][c*P +: P];
            g_prev    = prev_q[c*P +: P];
            b_now     = g2b(g_now);
            b_prev    = g2b(g_prev);
            multi_bit = $countones(g_now ^ g_prev) > 1;
        end

        assign bin_d[c*P +: P]   = b_now;
        // Modulo-2^P subtraction makes a wrap read as a forward step.
        assign delta_d[c*P +: P] = b_now - b_prev;
        assign chg_d[c]          = (g_now != g_prev);

        if (CHECK_EN != 0) begin : g_chk
            // A new error dominates a clear arriving in the same cycle.
            assign err_d[c] = multi_bit | (err_q[c] & ~err_clr[c]);
        end else begin : g_nochk
            assign err_d[c] = 1'b0;
        end
    end

    // Registered per-channel results, one cycle behind sync_gray.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            prev_q  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            chg_q   <= '0;
            err_q   <= '0;
        end else if (!srstn) begin
            prev_q  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            chg_q   <= '0;
            err_q   <= '0;
        end else begin
            prev_q  <= stage_q[NS-1];
            bin_q   <= bin_d;
            delta_q <= delta_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    assign sync_gray = stage_q[NS-1];
    assign sync_bin  = bin_q;
    assign ptr_delta = delta_q;
    assign ptr_chg   = chg_q;
    assign gray_err  = err_q;

endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
// Bench for corefifo_gray_ptr_sync: two instances (2 and 3 stages, 2 channels, P=4)
// share stimulus. A history-based model predicts every output each cycle.
module tb_corefifo_gray_ptr_sync;

    localparam int P   = 4;
    localparam int NCH = 2;
    localparam int W   = NCH * P;

    logic           clk = 1'b0;
    logic           arstn = 1'b0;
    logic           srstn = 1'b1;
    logic [W-1:0]   inp = '0;
    logic [NCH-1:0] err_clr = '0;

    logic [W-1:0]   sg_a, sb_a, pd_a, sg_b, sb_b, pd_b;
    logic [NCH-1:0] pc_a, ge_a, pc_b, ge_b;

    always #5 clk = ~clk;

    corefifo_gray_ptr_sync #(
        .NUM_STAGES(2), .ADDRWIDTH(3), .NUM_CH(2), .CHECK_EN(1)
    ) u_dut_a (
        .clk(clk), .arstn(arstn), .srstn(srstn), .inp(inp), .err_clr(err_clr),
        .sync_gray(sg_a), .sync_bin(sb_a), .ptr_delta(pd_a), .ptr_chg(pc_a),
        .gray_err(ge_a)
    );

    corefifo_gray_ptr_sync #(
        .NUM_STAGES(3), .ADDRWIDTH(3), .NUM_CH(2), .CHECK_EN(1)
    ) u_dut_b (
        .clk(clk), .arstn(arstn), .srstn(srstn), .inp(inp), .err_clr(err_clr),
        .sync_gray(sg_b), .sync_bin(sb_b), .ptr_delta(pd_b), .ptr_chg(pc_b),
        .gray_err(ge_b)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    // Binary value of a Gray code: the count whose Gray encoding it is.
    function automatic logic [3:0] m_g2b(input logic [3:0] g);
        for (int v = 0; v < 16; v++) begin
            if (gray4(v) == g) return v[3:0];
        end
        return 4'h0;
    endfunction

    function automatic int stages(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // hist[d][k] = inp sampled k edges ago (0 = latest), zeroed by any reset.
    logic [W-1:0]   hist  [2][8];
    logic [NCH-1:0] m_err [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) hist[d][k] = '0;
            m_err[d] = '0;
        end
    end

    always @(posedge clk or negedge arstn) begin
        if (!arstn || !srstn) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 8; k++) hist[d][k] = '0;
                m_err[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    logic [3:0] sg, pv;
                    sg = hist[d][stages(d)-1][c*P +: P];
                    pv = hist[d][stages(d)][c*P +: P];
                    m_err[d][c] = ($countones(sg ^ pv) > 1) | (m_err[d][c] & ~err_clr[c]);
                end
                for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = inp;
            end
        end
    end

    task automatic model_out(input int d, output logic [W-1:0] sg, output logic [W-1:0] sb,
                             output logic [W-1:0] pd, output logic [NCH-1:0] pc,
                             output logic [NCH-1:0] ge);
        int s = stages(d);
        sg = hist[d][s-1];
        for (int c = 0; c < NCH; c++) begin
            logic [3:0] gn, gp;
            gn = hist[d][s][c*P +: P];
            gp = hist[d][s+1][c*P +: P];
            sb[c*P +: P] = m_g2b(gn);
            pd[c*P +: P] = m_g2b(gn) - m_g2b(gp);
            pc[c] = (gn != gp);
        end
        ge = m_err[d];
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        logic [W-1:0]   e_sg, e_sb, e_pd;
        logic [NCH-1:0] e_pc, e_ge;
        model_out(0, e_sg, e_sb, e_pd, e_pc, e_ge);
        chk("a_sync_gray", sg_a, e_sg);
        chk("a_sync_bin",  sb_a, e_sb);
        chk("a_ptr_delta", pd_a, e_pd);
        chk("a_ptr_chg",   pc_a, e_pc);
        chk("a_gray_err",  ge_a, e_ge);
        model_out(1, e_sg, e_sb, e_pd, e_pc, e_ge);
        chk("b_sync_gray", sg_b, e_sg);
        chk("b_sync_bin",  sb_b, e_sb);
        chk("b_ptr_delta", pd_b, e_pd);
        chk("b_ptr_chg",   pc_b, e_pc);
        chk("b_gray_err",  ge_b, e_ge);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sg_a"}, sg_a, 0);
        chk({tag, "_sb_a"}, sb_a, 0);
        chk({tag, "_pd_a"}, pd_a, 0);
        chk({tag, "_pc_a"}, pc_a, 0);
        chk({tag, "_ge_a"}, ge_a, 0);
        chk({tag, "_sg_b"}, sg_b, 0);
        chk({tag, "_ge_b"}, ge_b, 0);
    endtask

    logic [3:0] cnt [NCH];

    initial begin
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        chk_all_zero("reset");

        // Single step 0000 -> 0001 on ch0, timing for 2 and 3 stages.
        repeat (9) @(negedge clk);
        inp = 8'h01;
        @(negedge clk);
        chk("t1_sg_a_edgeE", sg_a, 8'h00);
        @(negedge clk);
        chk("t1_sg_a", sg_a, 8'h01);
        chk("t2_sg_b_early", sg_b, 8'h00);
        @(negedge clk);
        chk("t1_sb_a", sb_a, 8'h01);
        chk("t1_pc_a", pc_a, 2'b01);
        chk("t1_pd_a", pd_a, 8'h01);
        chk("t2_sg_b", sg_b, 8'h01);
        @(negedge clk);
        chk("t1_pc_a_low", pc_a, 2'b00);
        chk("t2_sb_b", sb_b, 8'h01);
        chk("t2_pc_b", pc_b, 2'b01);

        // ch1 to constant 0101; its entry from 0 is a 2-bit jump, cleared afterwards.
        inp = 8'h50;
        repeat (6) @(negedge clk);
        chk("t5_ge_ch1_set", ge_a, 2'b10);
        err_clr = 2'b10;
        @(negedge clk);
        err_clr = 2'b00;
        repeat (4) @(negedge clk);
        chk("t5_ge_a_clr", ge_a, 2'b00);
        chk("t5_ge_b_clr", ge_b, 2'b00);
        chk("t5_sb_ch1", sb_a[7:4], 4'b0110);

        // Full Gray count on ch0, wrapping back to 0.
        for (int v = 0; v <= 16; v++) begin
            inp[3:0] = gray4(v);
            repeat (3) @(negedge clk);
            chk("t3_sb_a", sb_a[3:0], v & 15);
            if (v != 0) begin
                chk("t3_pd_a", pd_a[3:0], 4'h1);
                chk("t3_pc_a", pc_a[0], 1'b1);
            end
            @(negedge clk);
        end
        chk("t3_ge_a", ge_a, 2'b00);
        chk("t3_ge_b", ge_b, 2'b00);

        // Bad jump 0000 -> 0011, then a second bad jump with a coincident clear.
        inp[3:0] = 4'b0011;
        repeat (3) @(negedge clk);
        chk("t4_pd_a", pd_a[3:0], 4'h2);
        chk("t4_ge_a", ge_a, 2'b01);
        repeat (5) @(negedge clk);
        chk("t4_ge_a_held", ge_a, 2'b01);
        inp[3:0] = 4'b0110;
        repeat (2) @(negedge clk);
        err_clr = 2'b01;
        @(negedge clk);
        err_clr = 2'b00;
        chk("t4_ge_a_set_wins", ge_a, 2'b01);
        chk("t4_pd_a_jump", pd_a[3:0], 4'h2);
        repeat (5) @(negedge clk);
        err_clr = 2'b01;
        @(negedge clk);
        err_clr = 2'b00;
        chk("t4_ge_a_lone_clr", ge_a, 2'b00);
        chk("t4_ge_b_lone_clr", ge_b, 2'b00);

        // Randomised stream with a synchronous and an asynchronous reset along the way.
        cnt[0] = m_g2b(inp[3:0]);
        cnt[1] = m_g2b(inp[7:4]);
        for (int it = 0; it < 400; it++) begin
            for (int c = 0; c < NCH; c++) begin
                int r = $urandom_range(0, 9);
                if (r >= 5 && r < 8) cnt[c] = cnt[c] + 4'd1;
                else if (r == 8) cnt[c] = cnt[c] - 4'd1;
                else if (r == 9) cnt[c] = 4'($urandom_range(0, 15));
                inp[c*P +: P] = gray4(int'(cnt[c]));
            end
            err_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if (it == 150) begin
                srstn = 1'b0;
                @(negedge clk);
                srstn = 1'b1;
                chk_all_zero("srst");
            end else if (it == 300) begin
                #2 arstn = 1'b0;
                #1 chk_all_zero("arst");
                #1 arstn = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        err_clr = 2'b00;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
